ecc_serial_host: RTL and testbench
==================================

ECC_SERIAL_HOST -- requirements
Module: ecc_serial_host

Interface
REQ-001 SHALL have parameter BIT_NUM, default 32, operand/result word width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, watchdog limit in cycles (used only with ECC_HOST_TIMEOUT_EN).
REQ-003 SHALL use exactly one clock and an asynchronous, active-low reset; ports in order:
 clk  in  1  rising-edge clock
 rst  in  1  asynchronous active-low reset
 cmd_valid  in  1  operand set offered
 cmd_ready  out  1  host accepts operand set
 cmd_mode  in  1  operation mode, forwarded to core
 cmd_p, cmd_x, cmd_y, cmd_a  in  BIT_NUM each  parallel operands
 ser_valid  out  1  drives core i_p_a_valid
 ser_mode  out  1  drives core i_mode
 ser_p, ser_x, ser_y, ser_a  out  1 each  serial operand bits to core
 des_valid  in  1  core o_Pa_valid
 des_x, des_y  in  1 each  serial result bits from core
 rsp_valid  out  1  parallel result available
 rsp_ready  in  1  consumer accepts result
 rsp_x, rsp_y  out  BIT_NUM each  parallel result
 rsp_err  out  1  result aborted by timeout

Function
REQ-004 SHALL implement FSM states IDLE, SEND, WAIT, RECV, DONE.
REQ-005 SHALL assert cmd_ready only in IDLE; handshake occurs on a rising edge with cmd_valid and cmd_ready both 1.
REQ-006 On handshake at edge T SHALL capture all four operands and cmd_mode, and enter SEND.
REQ-007 In SEND SHALL drive ser_valid=1 for exactly BIT_NUM consecutive cycles, MSB first: cycle k (k=0..BIT_NUM-1) after T carries bit BIT_NUM-1-k of each operand on ser_p/x/y/a.
REQ-008 SHALL hold ser_mode at captured mode from SEND through DONE; ser_* data SHALL be 0 whenever ser_valid=0.
REQ-009 After the last SEND bit SHALL enter WAIT with ser_valid=0.
REQ-010 In WAIT/RECV SHALL sample des_x/des_y on each rising edge where des_valid=1, first sample = MSB, shifting left into result registers.
REQ-011 Gaps in des_valid SHALL be tolerated; only valid cycles count; des_valid in IDLE, SEND, DONE SHALL be ignored.
REQ-012 After the BIT_NUM-th sample SHALL enter DONE; rsp_valid=1 the following cycle with rsp_x/rsp_y stable.
REQ-013 rsp_valid, rsp_x, rsp_y, rsp_err SHALL hold until rsp_valid && rsp_ready on an edge, then return to IDLE (cmd_ready=1 next cycle).
REQ-014 Bit counter SHALL be ceil(log2(BIT_NUM+1)) wide; no wrap beyond BIT_NUM.
REQ-015 cmd_valid while not IDLE SHALL be ignored; no operand overwrite.

Reset
REQ-016 rst=0 SHALL immediately, regardless of clock, force IDLE, clear counters and shift registers, and drive cmd_ready=0 during reset, ser_valid=0, ser_*=0, ser_mode=0, rsp_valid=0, rsp_x=rsp_y=0, rsp_err=0.
REQ-017 First edge after rst deasserts SHALL see cmd_ready=1; reset mid-transfer SHALL abandon the transfer with no response.

Configuration
REQ-018 With ECC_HOST_TIMEOUT_EN defined: a counter SHALL run in WAIT/RECV; reaching TIMEOUT_CYCLES SHALL enter DONE with rsp_err=1, rsp_x=rsp_y=0.
REQ-019 Without ECC_HOST_TIMEOUT_EN: no watchdog logic, rsp_err tied 0, WAIT may last indefinitely.

Structure
REQ-020 Shared package ecc_host_pkg SHALL hold the FSM state enumeration, default BIT_NUM, and default TIMEOUT_CYCLES.
REQ-021 A sub-module ecc_bit_shifter (parallel-load MSB-first shift out, serial shift-in) SHALL be instantiated once per serial lane.

Verification
REQ-022 cmd_p=0x8000_0001 handshake -> ser_valid high 32 cycles, ser_p = 1,0…0,1; ser_valid low next cycle.
REQ-023 Core model returns x=0xDEADBEEF, y=0x12345678 contiguously -> rsp_valid 1 cycle after 32nd sample, rsp_x=0xDEADBEEF, rsp_y=0x12345678.
REQ-024 Same as REQ-023 with des_valid low every 3rd cycle -> identical rsp values, no extra/missing bits.
REQ-025 rsp_ready held 0 for 10 cycles; second cmd_valid offered -> rsp stable, cmd_ready=0, second command not accepted until after response handshake.
REQ-026 rst pulsed low at SEND bit 15 -> all outputs 0 immediately, cmd_ready=1 after release, no rsp_valid.
REQ-027 With ECC_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=100, des_valid never asserted -> rsp_valid with rsp_err=1, rsp_x=rsp_y=0, 100 cycles after WAIT entry.

Source files
------------

// File: rtl/ecc_host_pkg.sv
// Shared definitions for the ECC serial host: FSM state encoding and default sizing.
package ecc_host_pkg;

  localparam int unsigned ECC_BIT_NUM_DEF = 32;
  localparam int unsigned ECC_TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    RECV,
    DONE
  } host_state_e;

endpackage

// File: rtl/ecc_bit_shifter.sv
// One serial lane: parallel load, MSB-first shift out, and serial shift-in at the LSB.
module ecc_bit_shifter
  import ecc_host_pkg::*;
#(
  parameter int unsigned WIDTH = ECC_BIT_NUM_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             shift_in,
  output logic [WIDTH-1:0] word
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (load) begin
      word <= load_data;
    end else if (shift) begin
      word <= {word[WIDTH-2:0], shift_in};
    end
  end

endmodule

// File: rtl/ecc_serial_host.sv
// Serialises an operand set to the ECC core and deserialises its result.
// Optional response watchdog is enabled with `define ECC_HOST_TIMEOUT_EN.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for an operand set
// SEND  | shifting operands out MSB first, ser_valid high
// WAIT  | operands sent, no result bit seen yet
// RECV  | collecting result bits on des_valid
// DONE  | response held until rsp_ready
module ecc_serial_host
  import ecc_host_pkg::*;
#(
  parameter int unsigned BIT_NUM        = ECC_BIT_NUM_DEF,
  parameter int unsigned TIMEOUT_CYCLES = ECC_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_mode,
  input  logic [BIT_NUM-1:0] cmd_p,
  input  logic [BIT_NUM-1:0] cmd_x,
  input  logic [BIT_NUM-1:0] cmd_y,
  input  logic [BIT_NUM-1:0] cmd_a,
  output logic               ser_valid,
  output logic               ser_mode,
  output logic               ser_p,
  output logic               ser_x,
  output logic               ser_y,
  output logic               ser_a,
  input  logic               des_valid,
  input  logic               des_x,
  input  logic               des_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BIT_NUM-1:0] rsp_x,
  output logic [BIT_NUM-1:0] rsp_y,
  output logic               rsp_err
);

  localparam int unsigned      CNT_W    = $clog2(BIT_NUM + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_NUM - 1);

  host_state_e        state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic               mode_q;
  logic               load, tx_shift, rx_shift, rx_clear;
  logic               rx_phase, timeout_hit;
  logic [BIT_NUM-1:0] p_word, x_word, y_word, a_word;
  logic               unused_bits;

  assign rx_phase = (state == WAIT) || (state == RECV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      mode_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      if (load) mode_q <= cmd_mode;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    load        = 1'b0;
    tx_shift    = 1'b0;
    rx_shift    = 1'b0;
    rx_clear    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          load        = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        tx_shift = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_nxt = '0;
          state_nxt   = WAIT;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      WAIT, RECV: begin
        // A watchdog expiry wins over a result bit arriving on the same edge.
        if (timeout_hit) begin
          rx_clear    = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = DONE;
        end else if (des_valid) begin
          rx_shift = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
            state_nxt   = DONE;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            state_nxt   = RECV;
          end
        end
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // x/y lanes shift operands out, then reuse the same register to collect the result.
  ecc_bit_shifter #(.WIDTH(BIT_NUM)) u_lane_p (
    .clk(clk), .rst(rst), .clear(1'b0), .load(load), .load_data(cmd_p),
    .shift(tx_shift), .shift_in(1'b0), .word(p_word)
  );

  ecc_bit_shifter #(.WIDTH(BIT_NUM)) u_lane_x (
    .clk(clk), .rst(rst), .clear(rx_clear), .load(load), .load_data(cmd_x),
    .shift(tx_shift | rx_shift), .shift_in(rx_shift & des_x), .word(x_word)
  );

  ecc_bit_shifter #(.WIDTH(BIT_NUM)) u_lane_y (
    .clk(clk), .rst(rst), .clear(rx_clear), .load(load), .load_data(cmd_y),
    .shift(tx_shift | rx_shift), .shift_in(rx_shift & des_y), .word(y_word)
  );

  ecc_bit_shifter #(.WIDTH(BIT_NUM)) u_lane_a (
    .clk(clk), .rst(rst), .clear(1'b0), .load(load), .load_data(cmd_a),
    .shift(tx_shift), .shift_in(1'b0), .word(a_word)
  );

`ifdef ECC_HOST_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr;
  logic             err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr <= '0;
    end else if ((state == SEND) && (bit_cnt == LAST_BIT)) begin
      tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
    end else if (rx_phase && (tmr != '0)) begin
      tmr <= tmr - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end else if ((state == DONE) && rsp_ready) begin
      err_q <= 1'b0;
    end
  end

  assign timeout_hit = rx_phase && (tmr == '0);
  assign rsp_err     = (state == DONE) && err_q;
  assign unused_bits = ^{p_word[BIT_NUM-2:0], a_word[BIT_NUM-2:0]};
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
  assign unused_bits = ^{p_word[BIT_NUM-2:0], a_word[BIT_NUM-2:0], (TIMEOUT_CYCLES > 0)};
`endif

  // cmd_ready is gated by rst so it reads low while reset is held.
  assign cmd_ready = (state == IDLE) && rst;
  assign ser_valid = (state == SEND);
  assign ser_mode  = (state != IDLE) && mode_q;
  assign ser_p     = ser_valid && p_word[BIT_NUM-1];
  assign ser_x     = ser_valid && x_word[BIT_NUM-1];
  assign ser_y     = ser_valid && y_word[BIT_NUM-1];
  assign ser_a     = ser_valid && a_word[BIT_NUM-1];
  assign rsp_valid = (state == DONE);
  assign rsp_x     = rsp_valid ? x_word : '0;
  assign rsp_y     = rsp_valid ? y_word : '0;

endmodule

// File: tb/tb_ecc_serial_host.sv
// Scoreboard bench for ecc_serial_host with a behavioural ECC core model.
// Build with ECC_HOST_TIMEOUT_EN defined to also exercise the watchdog.
module tb_ecc_serial_host;

  localparam int W   = 32;
  localparam int TMO = 100;

  typedef struct {
    logic         m;
    logic [W-1:0] p, x, y, a;
  } op_t;

  typedef struct {
    logic [W-1:0] x, y;
    logic         err;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_mode;
  logic [W-1:0] cmd_p, cmd_x, cmd_y, cmd_a;
  logic         ser_valid, ser_mode, ser_p, ser_x, ser_y, ser_a;
  logic         des_valid, des_x, des_y;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0] rsp_x, rsp_y;

  int   tests = 0;
  int   fails = 0;
  int   n_rsp = 0;
  int   stall_seen = 0;
  bit   core_mute = 0;
  op_t  op_q[$];
  res_t exp_q[$];
  res_t res_q[$];

  ecc_serial_host #(.BIT_NUM(W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_p(cmd_p), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_a(cmd_a),
    .ser_valid(ser_valid), .ser_mode(ser_mode),
    .ser_p(ser_p), .ser_x(ser_x), .ser_y(ser_y), .ser_a(ser_a),
    .des_valid(des_valid), .des_x(des_x), .des_y(des_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour of the ECC core: the host must pass operands through untouched.
  function automatic res_t core_fn(input op_t o);
    res_t r;
    r.x   = o.x ^ o.a;
    r.y   = o.y ^ o.p ^ (o.m ? 32'hFFFF_0000 : 32'h0);
    r.err = 1'b0;
    return r;
  endfunction

  // Core side, receive: rebuild operands from the serial lanes.
  initial begin
    int           n = 0;
    bit           chk_end = 0;
    bit           mode_bad = 0;
    logic         m_first = 0;
    op_t          got, o;
    forever begin
      @(negedge clk);
      if (!rst) begin
        n = 0; chk_end = 0;
        continue;
      end
      if (chk_end) begin
        check("ser_valid_after_last", ser_valid, 0);
        chk_end = 0;
      end
      if (ser_valid) begin
        if (n == 0) begin m_first = ser_mode; mode_bad = 0; end
        else if (ser_mode !== m_first) mode_bad = 1;
        got.p = {got.p[W-2:0], ser_p};
        got.x = {got.x[W-2:0], ser_x};
        got.y = {got.y[W-2:0], ser_y};
        got.a = {got.a[W-2:0], ser_a};
        n++;
        if (n == W) begin
          n = 0; chk_end = 1;
          got.m = m_first;
          if (!core_mute) begin
            if (op_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL ser_unexpected: serial transfer with no command issued");
            end else begin
              o = op_q.pop_front();
              check("ser_operands", {got.p, got.x, got.y, got.a}, {o.p, o.x, o.y, o.a});
              check("ser_mode", m_first, o.m);
              check("ser_mode_stable", mode_bad, 0);
              res_q.push_back(core_fn(got));
            end
          end
        end
      end else begin
        check("ser_contiguous", n, 0);
        check("ser_idle_zero", {ser_p, ser_x, ser_y, ser_a}, 0);
      end
    end
  end

  // Core side, respond: MSB first with per-transaction gap patterns, then junk des_valid.
  initial begin
    int   idx = 0;
    int   sent, c;
    bit   v;
    res_t r;
    des_valid = 0; des_x = 0; des_y = 0;
    forever begin
      while (res_q.size() == 0) begin @(posedge clk); #1; end
      r = res_q.pop_front();
      if (idx > 1) repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
      sent = 0; c = 0;
      while (sent < W) begin
        if (idx == 0)      v = 1;
        else if (idx == 1) v = (c % 3) != 2;
        else               v = $urandom_range(0, 3) != 0;
        des_valid = v;
        des_x = v ? r.x[W-1-sent] : 1'($urandom_range(0, 1));
        des_y = v ? r.y[W-1-sent] : 1'($urandom_range(0, 1));
        if (v) sent++;
        c++;
        @(posedge clk); #1;
      end
      // Result bits offered in DONE/IDLE must be ignored.
      des_valid = 1; des_x = 1'($urandom_range(0, 1)); des_y = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rsp_latency", rsp_valid, 1);
      repeat (2) begin
        @(posedge clk); #1;
        des_x = 1'($urandom_range(0, 1)); des_y = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      des_valid = 0; des_x = 0; des_y = 0;
      idx++;
    end
  end

  initial begin
    rsp_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (n_rsp == 2 && stall_seen < 10) rsp_ready = 0;
      else rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Response monitor.
  initial begin
    logic [64:0] prev;
    bit          have_prev = 0;
    res_t        e;
    forever begin
      @(negedge clk);
      if (!rst) begin have_prev = 0; continue; end
      if (rsp_valid) begin
        if (n_rsp == 2) stall_seen++;
        check("cmd_ready_in_done", cmd_ready, 0);
        check("ser_valid_in_done", ser_valid, 0);
        if (have_prev) check("rsp_stable", {rsp_err, rsp_x, rsp_y}, prev);
        prev = {rsp_err, rsp_x, rsp_y};
        have_prev = 1;
        if (rsp_ready) begin
          have_prev = 0;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_rsp: got x=%0h y=%0h err=%0b with nothing expected", rsp_x, rsp_y, rsp_err);
          end else begin
            e = exp_q.pop_front();
            check("rsp_x", rsp_x, e.x);
            check("rsp_y", rsp_y, e.y);
            check("rsp_err", rsp_err, e.err);
          end
          n_rsp++;
        end
      end
    end
  end

  task automatic drive_junk_cmd();
    cmd_mode = 1'($urandom_range(0, 1));
    cmd_p = $urandom; cmd_x = $urandom; cmd_y = $urandom; cmd_a = $urandom;
  endtask

  task automatic issue(input op_t o, input bit push_op, input res_t e, input bit push_exp);
    int guard = 0;
    bit ok = 1;
    cmd_valid = 1; cmd_mode = o.m;
    cmd_p = o.p; cmd_x = o.x; cmd_y = o.y; cmd_a = o.a;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      guard++;
      if (guard > 3000) begin
        ok = 0; tests++; fails++;
        $display("FAIL cmd_accept_timeout: cmd_ready=%0b required 1", cmd_ready);
        break;
      end
    end
    @(posedge clk); #1;
    if (ok && push_op) op_q.push_back(o);
    if (ok && push_exp) exp_q.push_back(e);
    cmd_valid = 0;
    drive_junk_cmd();
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin @(negedge clk); guard++; end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    op_t  o;
    res_t e;
    rst = 0; cmd_valid = 0;
    drive_junk_cmd();
    #3;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_ctrl", {ser_valid, ser_mode, ser_p, ser_x, ser_y, ser_a, rsp_valid, rsp_err}, 0);
    check("rst_rsp_data", {rsp_x, rsp_y}, 0);
    #19 rst = 1;
    #1 check("cmd_ready_after_rst", cmd_ready, 1);
    @(posedge clk); #1;

    for (int t = 0; t < 12; t++) begin
      if (t < 2) begin
        o.m = 0; o.p = 32'h8000_0001; o.x = 32'hDEAD_BEEF; o.y = 32'h9234_5679; o.a = 32'h0;
      end else begin
        o.m = 1'($urandom_range(0, 1));
        o.p = $urandom; o.x = $urandom; o.y = $urandom; o.a = $urandom;
      end
      issue(o, 1, core_fn(o), 1);
      if (t != 2) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    drain();

    // Reset during SEND bit 15 abandons the transfer.
    o.m = 1; o.p = $urandom; o.x = $urandom; o.y = $urandom; o.a = $urandom;
    issue(o, 0, e, 0);
    repeat (16) @(negedge clk);
    check("ser_valid_mid_send", ser_valid, 1);
    #2 rst = 0;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_ctrl", {ser_valid, ser_mode, ser_p, ser_x, ser_y, ser_a, rsp_valid, rsp_err}, 0);
    check("mid_rst_rsp_data", {rsp_x, rsp_y}, 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    #2 rst = 1;
    #1 check("cmd_ready_after_mid_rst", cmd_ready, 1);
    repeat (60) @(negedge clk);
    check("no_rsp_after_abort", rsp_valid, 0);

`ifdef ECC_HOST_TIMEOUT_EN
    begin
      int  n = 0;
      bit  seen = 0;
      core_mute = 1;
      o.m = 0; o.p = $urandom; o.x = $urandom; o.y = $urandom; o.a = $urandom;
      e.x = 0; e.y = 0; e.err = 1;
      @(posedge clk); #1;
      issue(o, 0, e, 1);
      for (int c = 0; c < TMO + 300; c++) begin
        @(negedge clk);
        if (ser_valid) seen = 1;
        else if (seen) begin
          n++;
          if (rsp_valid) break;
        end
      end
      check("timeout_latency", n, TMO + 1);
      drain();
      core_mute = 0;
    end
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
